// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single-port, write-first,
// synchronous block RAM. Port 0 is the CPU core, port 1 a second master
// (display scanner, loader). One access is accepted per clock. The winning
// access is registered onto the RAM pins, and read data returns to its owner
// two cycles after the grant.
//
// Optional feature: define MEM_ARB_LOCK_EN to build the ownership-lock logic.
// A granted port that asserted pX_lock keeps the RAM on the following cycles
// while it keeps requesting. The lock is capped at LOCK_MAX consecutive
// re-grants, after which one normal arbitration is forced.
//
// Parameters
//   ADDR_W    word-address width
//   DATA_W    data width
//   LOCK_MAX  maximum consecutive locked re-grants (1..255)
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   pX_req/we/addr/wdata      access request; held stable until pX_gnt
//   pX_lock                   keep ownership (MEM_ARB_LOCK_EN builds only)
//   pX_gnt                    combinational grant, access accepted this cycle
//   pX_rvalid, pX_rdata       read return, two cycles after the grant
//   mem_addr/mem_dout/mem_we  registered RAM pins
//   mem_din                   RAM read data, one cycle after mem_addr
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_din
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  // Port that won the most recent grant; the other port wins the next tie.
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              mem_we_q, mem_we_d;

  // Read-return pipeline: stage 1 lines up with mem_addr on the RAM pins,
  // stage 2 with mem_din coming back from the RAM.
  logic s1_vld_q, s1_vld_d, s1_own_q, s1_own_d;
  logic s2_vld_q, s2_vld_d, s2_own_q, s2_own_d;

  logic              grant_any;
  logic              grant_port;
  logic              lock_hit;
  logic              lock_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_LOCK_EN
  logic       lock_vld_q, lock_vld_d;
  logic       lock_own_q, lock_own_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       sel_lock;

  // The lock holds only while the owner keeps requesting and the run of
  // locked re-grants has not yet reached the cap.
  assign lock_owner = lock_own_q;
  assign lock_hit   = lock_vld_q && (lock_own_q ? p1_req : p0_req) &&
                      (lock_cnt_q < LOCK_MAX_C);
  assign sel_lock   = grant_port ? p1_lock : p0_lock;
`else
  logic       unused_lock;
  logic [7:0] unused_lock_max;

  assign lock_owner      = 1'b0;
  assign lock_hit        = 1'b0;
  assign unused_lock     = p0_lock | p1_lock;
  assign unused_lock_max = LOCK_MAX_C;
`endif

  // Arbitration: lock first, then round-robin against last_q.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (!reset) begin
      if (lock_hit) begin
        grant_any  = 1'b1;
        grant_port = lock_owner;
      end else if (p0_req && p1_req) begin
        grant_any  = 1'b1;
        grant_port = ~last_q;
      end else if (p0_req) begin
        grant_any  = 1'b1;
        grant_port = 1'b0;
      end else if (p1_req) begin
        grant_any  = 1'b1;
        grant_port = 1'b1;
      end
    end
  end

  assign p0_gnt    = grant_any & ~grant_port;
  assign p1_gnt    = grant_any &  grant_port;
  assign sel_we    = grant_port ? p1_we    : p0_we;
  assign sel_addr  = grant_port ? p1_addr  : p0_addr;
  assign sel_wdata = grant_port ? p1_wdata : p0_wdata;

  // Next-state: load the winner onto the RAM pins. When idle, address and
  // write data hold so the RAM pins do not toggle needlessly.
  always_comb begin
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    mem_we_d   = 1'b0;
    s1_vld_d   = 1'b0;
    s1_own_d   = 1'b0;
    s2_vld_d   = s1_vld_q;
    s2_own_d   = s1_own_q;
    if (grant_any) begin
      last_d     = grant_port;
      mem_addr_d = sel_addr;
      mem_dout_d = sel_wdata;
      mem_we_d   = sel_we;
      s1_vld_d   = ~sel_we;
      s1_own_d   = grant_port;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples its pre-edge inputs, independent of statement order.
    if (reset) begin
      last_q     <= 1'b1;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_we_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_own_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_own_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_we_q   <= mem_we_d;
      s1_vld_q   <= s1_vld_d;
      s1_own_q   <= s1_own_d;
      s2_vld_q   <= s2_vld_d;
      s2_own_q   <= s2_own_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // A lock is taken by the grant that carried pX_lock. The counter counts
  // locked re-grants only; any normal grant or idle cycle restarts it.
  always_comb begin
    lock_vld_d = grant_any & sel_lock;
    lock_own_d = grant_port;
    lock_cnt_d = (grant_any && lock_hit) ? lock_cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= 8'd0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_dout  = mem_dout_q;
  assign mem_we    = mem_we_q;
  assign p0_rvalid = s2_vld_q & ~s2_own_q;
  assign p1_rvalid = s2_vld_q &  s2_own_q;
  assign p0_rdata  = mem_din;
  assign p1_rdata  = mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with a write-first 32Kx16 RAM attached. A reference
// model written in terms of arbitration rules, a shadow memory, and a
// two-deep queue of pending read returns is compared against the DUT on every
// falling clock edge. Directed sequences pin the model with literal values,
// and a randomized phase follows. Built with LOCK_MAX = 4.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int LM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_we;
  logic [DW-1:0] mem_din;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lock(p0_lock),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_din(mem_din)
  );

  // Write-first synchronous RAM.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_dout;
      mem_din       <= mem_dout;
    end else begin
      mem_din <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            vld;
    bit            own;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  bit            m_we;
  rd_t           pend [2];          // pend[1] is due this cycle
  int            lock_owner = -1;
  int            lock_run   = 0;
  bit            regs_known = 1'b0;
  bit            exp_g [2];
  int            gcnt [2];
  int            rvcnt [2];

  always @(negedge clock) begin : cmp
    bit            rq [2];
    bit            wq [2];
    bit            lq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    bit            g_any;
    bit            locked;
    int            g;
    rd_t           empty;

    empty = '{vld: 1'b0, own: 1'b0, data: '0};
    rq[0] = p0_req; rq[1] = p1_req;
    wq[0] = p0_we;  wq[1] = p1_we;
    lq[0] = p0_lock; lq[1] = p1_lock;
    aq[0] = p0_addr; aq[1] = p1_addr;
    dq[0] = p0_wdata; dq[1] = p1_wdata;

    g_any  = 1'b0;
    locked = 1'b0;
    g      = 0;
    if (!reset) begin
`ifdef MEM_ARB_LOCK_EN
      if (lock_owner >= 0 && rq[lock_owner] && lock_run < LM) begin
        locked = 1'b1;
        g_any  = 1'b1;
        g      = lock_owner;
      end
`endif
      if (!locked) begin
        if (rq[0] && rq[1]) begin g_any = 1'b1; g = m_last ? 0 : 1; end
        else if (rq[0])     begin g_any = 1'b1; g = 0; end
        else if (rq[1])     begin g_any = 1'b1; g = 1; end
      end
    end

    check("p0_gnt", p0_gnt, g_any && g == 0);
    check("p1_gnt", p1_gnt, g_any && g == 1);
    if (regs_known) begin
      check("mem_we",   mem_we,   m_we);
      check("mem_addr", mem_addr, m_addr);
      check("mem_dout", mem_dout, m_dout);
      check("p0_rvalid", p0_rvalid, pend[1].vld && !pend[1].own);
      check("p1_rvalid", p1_rvalid, pend[1].vld &&  pend[1].own);
      if (pend[1].vld)
        check("rdata", pend[1].own ? p1_rdata : p0_rdata, pend[1].data);
    end

    if (p0_gnt === 1'b1) gcnt[0]++;
    if (p1_gnt === 1'b1) gcnt[1]++;
    if (p0_rvalid === 1'b1) rvcnt[0]++;
    if (p1_rvalid === 1'b1) rvcnt[1]++;

    if (reset) begin
      m_last     = 1'b1;
      m_we       = 1'b0;
      m_addr     = '0;
      m_dout     = '0;
      pend[0]    = empty;
      pend[1]    = empty;
      lock_owner = -1;
      lock_run   = 0;
      regs_known = 1'b1;
    end else begin
      pend[1] = pend[0];
      if (g_any) begin
        if (wq[g]) begin
          pend[0]        = empty;
          shadow[aq[g]]  = dq[g];
        end else begin
          pend[0] = '{vld: 1'b1, own: g[0], data: shadow[aq[g]]};
        end
        m_addr     = aq[g];
        m_dout     = dq[g];
        m_we       = wq[g];
        m_last     = g[0];
        lock_owner = lq[g] ? g : -1;
        lock_run   = locked ? lock_run + 1 : 0;
      end else begin
        pend[0]    = empty;
        m_we       = 1'b0;
        lock_owner = -1;
        lock_run   = 0;
      end
    end
    exp_g[0] = g_any && g == 0;
    exp_g[1] = g_any && g == 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_lock = 0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  bit            rq [2];
  bit            wq [2];
  bit            lq [2];
  logic [AW-1:0] aq [2];
  logic [DW-1:0] dq [2];

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i) ^ 16'h5A5A;
      shadow[i] = DW'(i) ^ 16'h5A5A;
    end
    ram[15'h2400]    = 16'hBEEF;
    shadow[15'h2400] = 16'hBEEF;

    // Single uncontested read.
    do_reset();
    p0_req = 1; p0_addr = 15'h2400;
    #3 check("t1_gnt_same_cycle", p0_gnt, 1);
    tick(); idle();
    #3 check("t1_mem_addr", mem_addr, 15'h2400);
    tick();
    #3 check("t1_p0_rvalid", p0_rvalid, 1);
    check("t1_p0_rdata", p0_rdata, 16'hBEEF);
    check("t1_p1_rvalid", p1_rvalid, 0);
    tick();
    #3 check("t1_p0_rvalid_drop", p0_rvalid, 0);

    // Continuous contention: strict alternation, 4 returns per port.
    do_reset();
    gcnt[0] = 0; gcnt[1] = 0; rvcnt[0] = 0; rvcnt[1] = 0;
    p0_req = 1; p0_addr = 15'd10; p1_req = 1; p1_addr = 15'd20;
    for (int i = 0; i < 8; i++) begin
      #3 check("t2_alt_p0", p0_gnt, (i % 2) == 0);
      tick();
    end
    idle();
    tick(); tick(); tick();
    check("t2_gcnt0", gcnt[0], 4);
    check("t2_gcnt1", gcnt[1], 4);
    check("t2_rvcnt0", rvcnt[0], 4);
    check("t2_rvcnt1", rvcnt[1], 4);

    // Write by p1 then read-after-write by p0.
    do_reset();
    p1_req = 1; p1_we = 1; p1_addr = 15'd5; p1_wdata = 16'h1234;
    #3 check("t3_p1_gnt", p1_gnt, 1);
    tick(); idle();
    p0_req = 1; p0_addr = 15'd5;
    #3 check("t3_mem_we_t1", mem_we, 1);
    check("t3_p0_gnt", p0_gnt, 1);
    tick(); idle();
    #3 check("t3_mem_we_t2", mem_we, 0);
    tick();
    #3 check("t3_p0_rvalid", p0_rvalid, 1);
    check("t3_p0_rdata", p0_rdata, 16'h1234);

    // Reset during an in-flight read.
    do_reset();
    p0_req = 1; p0_addr = 15'd7;
    #3 check("t4_gnt", p0_gnt, 1);
    tick(); idle();
    reset = 1; p1_req = 1; p1_addr = 15'd3;
    #3 check("t4_no_gnt_in_reset", p1_gnt, 0);
    tick();
    reset = 0; idle();
    for (int i = 0; i < 3; i++) begin
      #3 check("t4_no_rvalid", p0_rvalid | p1_rvalid, 0);
      check("t4_mem_we", mem_we, 0);
      tick();
    end
    p0_req = 1; p1_req = 1;
    #3 check("t4_tie_p0", p0_gnt, 1);
    check("t4_tie_not_p1", p1_gnt, 0);
    tick(); idle(); tick(); tick(); tick();

    // p0 locks against continuous p1 requests.
    do_reset();
    p0_req = 1; p0_lock = 1; p0_addr = 15'd100; p1_req = 1; p1_addr = 15'd200;
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_LOCK_EN
      #3 check("t5_lock_p1", p1_gnt, (i % 6) == 5);
`else
      #3 check("t5_alt_p1", p1_gnt, (i % 2) == 1);
`endif
      tick();
    end
    idle(); tick(); tick(); tick();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int p = 0; p < 2; p++) rq[p] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(rq[p] && !exp_g[p] && ($urandom % 8) != 0)) begin
          rq[p] = ($urandom % 3) != 0;
          wq[p] = ($urandom % 2) != 0;
          lq[p] = ($urandom % 2) != 0;
          aq[p] = (($urandom % 4) == 0) ? AW'($urandom) : AW'($urandom % 16);
          dq[p] = DW'($urandom);
        end
      end
      reset   = ($urandom % 150) == 0;
      p0_req  = rq[0]; p0_we = wq[0]; p0_lock = lq[0];
      p0_addr = aq[0]; p0_wdata = dq[0];
      p1_req  = rq[1]; p1_we = wq[1]; p1_lock = lq[1];
      p1_addr = aq[1]; p1_wdata = dq[1];
      tick();
    end
    reset = 0;
    idle();
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
